// File: rtl/lake_static_sched_ag.sv
`default_nettype none
// ============================================================================
// Module   : lake_static_sched_ag
// Brief    : Multi-port static-schedule controller for the lakespec memory
//            tile. Each port walks its own affine iteration domain and emits
//            a cycle-exact valid strobe with a linear address.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          - clock
//   rst_n        - synchronous active-low reset
//   flush        - synchronous restart of all schedules (config unchanged)
//   stall        - (only with LAKE_SCHED_STALL_EN) freezes all schedules
//   config_sched - static config, port p at [p*PORT_CFG_W +: PORT_CFG_W]
//   port_valid   - port p accesses memory this cycle
//   port_addr    - address for port p, meaningful when port_valid[p]=1
//   port_done    - port p has completed its iteration domain
//   cycle_count  - cycles elapsed since flush/reset release
// Optional feature macro: LAKE_SCHED_STALL_EN (adds the stall input).
// Per-port config, LSB first:
//   enable[1], dim[4], MAX_DIM x {extent_m1, addr_delta, sched_delta},
//   addr_offset, sched_offset
// ============================================================================
module lake_static_sched_ag #(
   parameter int NUM_PORTS  = 2,
   parameter int MAX_DIM    = 6,
   parameter int EXT_W      = 16,
   parameter int ADDR_W     = 9,
   parameter int CYC_W      = 16,
   localparam int DIM_CFG_W  = EXT_W + ADDR_W + CYC_W,
   localparam int PORT_CFG_W = 1 + 4 + MAX_DIM*DIM_CFG_W + ADDR_W + CYC_W
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
`ifdef LAKE_SCHED_STALL_EN
   input  logic                            stall,
`endif
   input  logic [NUM_PORTS*PORT_CFG_W-1:0] config_sched,
   output logic [NUM_PORTS-1:0]            port_valid,
   output logic [NUM_PORTS*ADDR_W-1:0]     port_addr,
   output logic [NUM_PORTS-1:0]            port_done,
   output logic [CYC_W-1:0]                cycle_count
);

   localparam logic [3:0] C_MAX_DIM = 4'(MAX_DIM);

   logic             w_stall;
   logic [CYC_W-1:0] r_cyc;

`ifdef LAKE_SCHED_STALL_EN
   assign w_stall = stall;
`else
   assign w_stall = 1'b0;
`endif

   // Shared time base: held at 0 during flush, frozen while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cyc <= '0;
      end else if (flush) begin
         r_cyc <= '0;
      end else if (!w_stall) begin
         r_cyc <= r_cyc + CYC_W'(1);
      end
   end

   assign cycle_count = r_cyc;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      localparam int BASE = p*PORT_CFG_W;
      localparam int OFFS = BASE + 5 + MAX_DIM*DIM_CFG_W;

      logic              w_en;
      logic [3:0]        w_dim_raw;
      logic [3:0]        w_ndim;
      logic [EXT_W-1:0]  w_ext [MAX_DIM];
      logic [ADDR_W-1:0] w_ad  [MAX_DIM];
      logic [CYC_W-1:0]  w_sd  [MAX_DIM];
      logic [ADDR_W-1:0] w_aoff;
      logic [CYC_W-1:0]  w_soff;

      logic              w_found;
      logic [3:0]        w_k;
      logic [ADDR_W-1:0] w_sel_ad;
      logic [CYC_W-1:0]  w_sel_sd;
      logic              w_fire;

      logic [EXT_W-1:0]  r_iter [MAX_DIM];
      logic [ADDR_W-1:0] r_addr;
      logic [CYC_W-1:0]  r_next;
      logic              r_done;

      assign w_en      = config_sched[BASE];
      assign w_dim_raw = config_sched[BASE+1 +: 4];
      assign w_aoff    = config_sched[OFFS +: ADDR_W];
      assign w_soff    = config_sched[OFFS+ADDR_W +: CYC_W];

      // dim=0 behaves as a single loop; oversize depth is clamped.
      assign w_ndim = (w_dim_raw == 4'd0)      ? 4'd1      :
                      (w_dim_raw > C_MAX_DIM)  ? C_MAX_DIM : w_dim_raw;

      for (genvar gd = 0; gd < MAX_DIM; gd++) begin : g_dim
         localparam int DB = BASE + 5 + gd*DIM_CFG_W;
         assign w_ext[gd] = config_sched[DB +: EXT_W];
         assign w_ad[gd]  = config_sched[DB+EXT_W +: ADDR_W];
         assign w_sd[gd]  = config_sched[DB+EXT_W+ADDR_W +: CYC_W];
      end

      // Odometer carry search: lowest active dim that has not reached its
      // extent. No such dim means the current fire is the last one.
      always_comb begin
         w_found  = 1'b0;
         w_k      = '0;
         w_sel_ad = '0;
         w_sel_sd = '0;
         for (int d = 0; d < MAX_DIM; d++) begin
            if (!w_found && (4'(d) < w_ndim) && (r_iter[d] != w_ext[d])) begin
               w_found  = 1'b1;
               w_k      = 4'(d);
               w_sel_ad = w_ad[d];
               w_sel_sd = w_sd[d];
            end
         end
      end

      // rst_n gates the strobe so nothing fires during a reset cycle.
      assign w_fire = rst_n & w_en & ~r_done & ~flush & ~w_stall &
                      (r_cyc == r_next);

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int d = 0; d < MAX_DIM; d++) r_iter[d] <= '0;
            r_addr <= '0;
            r_next <= '0;
            r_done <= 1'b0;
         end else if (flush) begin
            for (int d = 0; d < MAX_DIM; d++) r_iter[d] <= '0;
            r_addr <= w_aoff;
            r_next <= w_soff;
            r_done <= 1'b0;
         end else if (w_fire) begin
            if (w_found) begin
               for (int d = 0; d < MAX_DIM; d++) begin
                  if (4'(d) < w_k) begin
                     r_iter[d] <= '0;
                  end else if (4'(d) == w_k) begin
                     r_iter[d] <= r_iter[d] + EXT_W'(1);
                  end
               end
               r_addr <= r_addr + w_sel_ad;
               r_next <= r_next + w_sel_sd;
            end else begin
               r_done <= 1'b1;
            end
         end
      end

      assign port_valid[p]                = w_fire;
      assign port_addr[p*ADDR_W +: ADDR_W] = r_addr;
      assign port_done[p]                 = r_done;
   end

endmodule
`default_nettype wire

// File: tb/tb_lake_static_sched_ag.sv
`default_nettype none
// ============================================================================
// Module   : tb_lake_static_sched_ag
// Brief    : Self-checking bench for lake_static_sched_ag. A point-set model
//            built from loop strides predicts strobe, address and done per
//            cycle; directed literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lake_static_sched_ag;

   localparam int NP = 2;
   localparam int MD = 6;
   localparam int EW = 16;
   localparam int AW = 9;
   localparam int CW = 16;
   localparam int DW = EW + AW + CW;
   localparam int PW = 5 + MD*DW + AW + CW;
   localparam int TN = 1024;

   typedef int arr_t [MD];

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             stall_s = 1'b0;
   logic [NP*PW-1:0] cfg = '0;
   logic [NP-1:0]    port_valid;
   logic [NP*AW-1:0] port_addr;
   logic [NP-1:0]    port_done;
   logic [CW-1:0]    cycle_count;

   int checks = 0;
   int errors = 0;

   // Model: set of (time -> address) points per port.
   bit          tv [NP][TN];
   logic [AW-1:0] ta [NP][TN];
   int          last_t [NP];
   bit          men [NP];
   logic [AW-1:0] maoff [NP];
   int          mc = 0;
   bit          prev_rst = 1'b0;
   bit          prev_fl = 1'b0;

   lake_static_sched_ag dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
`ifdef LAKE_SCHED_STALL_EN
      .stall        (stall_s),
`endif
      .config_sched (cfg),
      .port_valid   (port_valid),
      .port_addr    (port_addr),
      .port_done    (port_done),
      .cycle_count  (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Writes the port config (deltas derived from strides the way a compiler
   // would) and enumerates every point of the iteration domain.
   task automatic build(input int p, input bit en, input int dim, input arr_t ext,
                        input arr_t ast, input arr_t sst, input int aoff, input int soff);
      int base, nd, total, r, a, t, i, span_a, span_s;
      base = p*PW;
      nd = (dim == 0) ? 1 : ((dim > MD) ? MD : dim);
      cfg[base] = en;
      cfg[base+1 +: 4] = 4'(dim);
      span_a = 0;
      span_s = 0;
      for (int d = 0; d < MD; d++) begin
         cfg[base+5+d*DW +: EW]       = EW'(ext[d]);
         cfg[base+5+d*DW+EW +: AW]    = AW'(ast[d] - span_a);
         cfg[base+5+d*DW+EW+AW +: CW] = CW'(sst[d] - span_s);
         span_a += ext[d]*ast[d];
         span_s += ext[d]*sst[d];
      end
      cfg[base+5+MD*DW +: AW]    = AW'(aoff);
      cfg[base+5+MD*DW+AW +: CW] = CW'(soff);
      for (int c = 0; c < TN; c++) begin
         tv[p][c] = 1'b0;
         ta[p][c] = '0;
      end
      last_t[p] = -1;
      men[p] = en;
      maoff[p] = AW'(aoff);
      total = 1;
      for (int d = 0; d < nd; d++) total *= ext[d] + 1;
      if (en) begin
         for (int n = 0; n < total; n++) begin
            r = n; a = aoff; t = soff;
            for (int d = 0; d < nd; d++) begin
               i = r % (ext[d] + 1);
               r = r / (ext[d] + 1);
               a += i*ast[d];
               t += i*sst[d];
            end
            tv[p][t] = 1'b1;
            ta[p][t] = AW'(a);
            if (t > last_t[p]) last_t[p] = t;
         end
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      bit ev;
      if (!rst_n) begin
         if (prev_rst) begin
            chk("rst_valid", 32'(port_valid), 0);
            chk("rst_done", 32'(port_done), 0);
            chk("rst_cycle", 32'(cycle_count), 0);
            chk("rst_addr", 32'(port_addr), 0);
         end
         prev_rst = 1'b1; prev_fl = 1'b0; mc = 0;
      end else if (flush) begin
         chk("flush_valid", 32'(port_valid), 0);
         if (prev_rst || prev_fl) begin
            chk("flush_cycle", 32'(cycle_count), 0);
            chk("flush_done", 32'(port_done), 0);
         end
         if (prev_fl) begin
            for (int p = 0; p < NP; p++)
               chk("flush_addr", 32'(port_addr[p*AW +: AW]), 32'(maoff[p]));
         end
         prev_fl = 1'b1; prev_rst = 1'b0; mc = 0;
      end else begin
         chk("cycle_count", 32'(cycle_count), mc);
         for (int p = 0; p < NP; p++) begin
            ev = men[p] && !stall_s && (mc < TN) && tv[p][mc];
            chk("valid", 32'(port_valid[p]), 32'(ev));
            if (ev) chk("addr", 32'(port_addr[p*AW +: AW]), 32'(ta[p][mc]));
            chk("done", 32'(port_done[p]), 32'(men[p] && (mc > last_t[p])));
         end
         if (!stall_s) mc++;
         prev_rst = 1'b0; prev_fl = 1'b0;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg;
      @(negedge clk);
   endtask

   task automatic restart;
      flush = 1'b1;
      repeat (3) tick;
      flush = 1'b0;
   endtask

   localparam arr_t Z = '{0, 0, 0, 0, 0, 0};

   task automatic cfg_linear0;
      build(0, 1'b1, 1, '{63, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0}, 0, 0);
   endtask

   initial begin
      build(0, 1'b0, 1, Z, Z, Z, 0, 0);
      build(1, 1'b0, 1, Z, Z, Z, 0, 0);
      // Reset then long flush; everything must read 0.
      repeat (2) tick;
      rst_n = 1'b1;
      flush = 1'b1;
      repeat (16) tick;
      flush = 1'b0;
      at_neg; chk("post_flush_cc0", 32'(cycle_count), 0);
      tick;
      at_neg; chk("post_flush_cc1", 32'(cycle_count), 1);
      repeat (5) tick;

      // Linear write on port 0.
      cfg_linear0();
      build(1, 1'b0, 1, Z, Z, Z, 0, 0);
      chk("model_lin_last", 32'(last_t[0]), 63);
      restart();
      at_neg; chk("lin_v0", 32'(port_valid[0]), 1); chk("lin_a0", 32'(port_addr[AW-1:0]), 0);
      repeat (63) tick;
      at_neg; chk("lin_a63", 32'(port_addr[AW-1:0]), 63); chk("lin_d63", 32'(port_done[0]), 0);
      tick;
      at_neg; chk("lin_d64", 32'(port_done[0]), 1); chk("lin_v64", 32'(port_valid[0]), 0);
      repeat (5) tick;

      // 2D strided read on port 1.
      build(0, 1'b0, 1, Z, Z, Z, 0, 0);
      build(1, 1'b1, 2, '{3, 3, 0, 0, 0, 0}, '{2, 8, 0, 0, 0, 0}, '{1, 8, 0, 0, 0, 0}, 0, 10);
      chk("model_2d_t13", 32'(tv[1][13]), 1);
      chk("model_2d_t14", 32'(tv[1][14]), 0);
      chk("model_2d_last", 32'(last_t[1]), 37);
      restart();
      repeat (18) tick;
      at_neg; chk("2d_v18", 32'(port_valid[1]), 1); chk("2d_a18", 32'(port_addr[AW +: AW]), 8);
      repeat (19) tick;
      at_neg; chk("2d_a37", 32'(port_addr[AW +: AW]), 30);
      tick;
      at_neg; chk("2d_d38", 32'(port_done[1]), 1);
      repeat (3) tick;

      // Concurrent ports.
      cfg_linear0();
      build(1, 1'b1, 1, '{59, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0}, 256, 4);
      restart();
      repeat (4) tick;
      at_neg;
      chk("cc_v4", 32'(port_valid), 3);
      chk("cc_a1", 32'(port_addr[AW +: AW]), 256);
      chk("cc_a0", 32'(port_addr[AW-1:0]), 4);
      repeat (60) tick;
      at_neg; chk("cc_done", 32'(port_done), 3);
      repeat (3) tick;

      // Mid-run flush, then mid-run reset.
      cfg_linear0();
      build(1, 1'b0, 1, Z, Z, Z, 0, 0);
      restart();
      repeat (20) tick;
      flush = 1'b1;
      at_neg; chk("mf_drop", 32'(port_valid[0]), 0);
      repeat (3) tick;
      flush = 1'b0;
      at_neg;
      chk("mf_v", 32'(port_valid[0]), 1);
      chk("mf_a", 32'(port_addr[AW-1:0]), 0);
      chk("mf_cc", 32'(cycle_count), 0);
      repeat (30) tick;
      rst_n = 1'b0;
      at_neg; chk("rst_nostrobe", 32'(port_valid), 0);
      repeat (2) tick;
      rst_n = 1'b1;
      flush = 1'b1;
      repeat (2) tick;
      flush = 1'b0;
      repeat (70) tick;

`ifdef LAKE_SCHED_STALL_EN
      // Stall for 5 cycles starting at cycle 10.
      cfg_linear0();
      restart();
      repeat (10) tick;
      stall_s = 1'b1;
      at_neg; chk("st_v", 32'(port_valid[0]), 0);
      repeat (5) tick;
      stall_s = 1'b0;
      at_neg;
      chk("st_a10", 32'(port_addr[AW-1:0]), 10);
      chk("st_v10", 32'(port_valid[0]), 1);
      repeat (53) tick;
      at_neg; chk("st_d_early", 32'(port_done[0]), 0);
      tick;
      at_neg; chk("st_d69", 32'(port_done[0]), 1);
      repeat (3) tick;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lake_static_sched_ag.md
Name: lake_static_sched_ag

Overview:
- Parametrised, multi-port static-schedule controller for the lakespec memory tile. Successor to the fixed two-port, single-bitstream schedule path.
- Each port runs its own affine iteration domain. Each port produces a cycle-exact valid strobe and a linear address, both derived from a flat configuration vector.
- Sits between the tile config register and the memory/port datapath. Drives write enables for input ports and read enables for output ports.

Parameters:
- NUM_PORTS, 2, number of independent schedule/address channels.
- MAX_DIM, 6, maximum loop nest depth per port.
- EXT_W, 16, width of each loop extent field.
- ADDR_W, 9, address width (512-word memory).
- CYC_W, 16, schedule/cycle counter width.
- PORT_CFG_W, 1+4+MAX_DIM*(EXT_W+ADDR_W+CYC_W)+ADDR_W+CYC_W, derived (localparam); per-port config width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- flush  in  1  synchronous restart of all schedules; config is unchanged
- config_sched  in  NUM_PORTS*PORT_CFG_W  static config; port p at [p*PORT_CFG_W +: PORT_CFG_W]
- port_valid  out  NUM_PORTS  port p accesses memory this cycle
- port_addr  out  NUM_PORTS*ADDR_W  address for port p, meaningful when port_valid[p]=1
- port_done  out  NUM_PORTS  port p has completed its whole iteration domain
- cycle_count  out  CYC_W  cycles elapsed since flush/reset release

Behaviour:
- Per-port config fields, LSB first:
  - enable[1], dim[4]
  - per dim d=0..MAX_DIM-1: extent_m1[EXT_W], addr_delta[ADDR_W], sched_delta[CYC_W]
  - addr_offset[ADDR_W], sched_offset[CYC_W]
- Config is static and must be held stable whenever flush=0; no internal config latch.
- Reset (rst_n=0 at clk edge), all registers cleared:
  - cycle_count=0; iterators=0; port_valid=0; port_addr=0; port_done=0.
- Reset has priority over flush. Reset mid-schedule aborts immediately; no strobe is emitted in the reset cycle.
- Flush (flush=1):
  - cycle_count held at 0; iterators=0; done=0.
  - addr register = addr_offset; next_time = sched_offset.
  - port_valid forced 0.
  - The first cycle after flush falls sees cycle_count=0.
- Running:
  - cycle_count increments by 1 every cycle and wraps modulo 2^CYC_W.
- Fire condition, combinational from registers, zero latency:
  - port_valid[p] = enable & ~done & ~flush & (cycle_count == next_time).
  - port_addr[p] = current addr register.
- On fire, iterator update (odometer):
  - Let k = lowest dim with iter[k] != extent_m1[k].
  - iter[0..k-1] <- 0; iter[k] += 1.
  - addr += addr_delta[k]; next_time += sched_delta[k].
  - Deltas are compiler-precomputed (stride_k minus the sum of lower-dim spans). Addition is modulo 2^ADDR_W / 2^CYC_W; deltas are two's complement.
- Completion:
  - If no such k exists within dims 0..dim-1, the current fire is the last. done <- 1 and stays 1 until flush or reset.
  - Dims >= dim are ignored. dim=0 is treated as dim=1. dim > MAX_DIM is clamped to MAX_DIM.
  - extent_m1=0 gives a single-iteration dim.
- Ports are fully independent; simultaneous fires on all ports are legal and each updates in the same cycle.
- enable=0: port_valid and port_done stay 0 and the iterators do not advance.
- A missed schedule (next_time < cycle_count because of a bad config) is not detected. The port fires again only after cycle_count wraps.

Optional Feature:
- Macro LAKE_SCHED_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - While stall=1: cycle_count, iterators and done are frozen, and port_valid is forced 0.
  - Flush and reset override stall.
- Undefined: no stall port; the counter free-runs as specified above.

Test Plan:
- Reset/flush: hold rst_n=0 for 2 cycles, then flush=1 for 16 cycles, then release.
  - All outputs stay 0 throughout.
  - cycle_count reads 0, 1, 2, ... starting from the first post-flush cycle.
- Linear write, port0: dim=1, extent_m1=63, addr_delta=1, sched_delta=1, addr_offset=0, sched_offset=0.
  - port_valid high on cycles 0..63 with addresses 0..63.
  - port_done=1 from cycle 64.
- 2D strided read, port1: dim=2, ext_m1={3,3}, addr_delta={2,2}, sched_delta={1,5}, sched_offset=10.
  - Fires at cycles 10-13, 18-21, 26-29, 34-37.
  - Addresses 0,2,4,6,8,...,30.
- Concurrent ports: port0 as in the linear-write case; port1 with sched_offset=4, extent_m1=59, addr_delta=1, addr_offset=256.
  - Both valid on cycles 4..63; no interference.
  - port1 address at cycle 4 = 256.
- Mid-run flush: run the linear-write case; assert flush at cycle 20 for 3 cycles.
  - port_valid drops immediately.
  - After release, addresses restart at 0 from cycle_count=0.
- With LAKE_SCHED_STALL_EN: stall=1 at cycles 10..14 of the linear-write case.
  - No strobes during the stall.
  - Address 10 is emitted on the first unstalled cycle; port_done arrives 5 cycles later than without stall.
